comm_unpack: RTL and testbench

- Downstream stage of the receive path. Drains the 128-bit sample FIFO that the receiver fills and unpacks each word into 8 sample pairs (ad1/ad2, 8 bits each).
- Presents the pairs one per handshake on a valid/ready stream toward the FFT input.
- Tags frame boundaries every FRAME_LEN pairs so the FFT sees aligned frames.

---
 rtl/comm_unpack.sv | 107 ++++++++++
 tb/tb_comm_unpack.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/comm_unpack.sv
// Unpacks 128-bit sample-FIFO words into 8 (ad1, ad2) pairs on a valid/ready stream with sof/eof framing.
// Optional one-word prefetch for gap-free streaming: define COMM_UNPACK_PREFETCH_EN.
module comm_unpack #(
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = 6
) (
  input  logic         CLK,
  input  logic         RST,
  output logic         rd_en,
  input  logic [127:0] din,
  input  logic         empty,
  output logic [7:0]   out_ad1,
  output logic [7:0]   out_ad2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sof,
  output logic         eof
);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t             state, state_nxt;
  logic [7:0][15:0]   word_q;
  logic [2:0]         idx;
  logic [CNT_W-1:0]   pair_cnt;
  logic               hs, last;
  logic               pf_rd, refill;
  logic [7:0][15:0]   refill_word;

  assign out_valid = (state == SEND);
  assign hs        = out_valid && out_ready;
  assign last      = hs && (idx == 3'd7);

`ifdef COMM_UNPACK_PREFETCH_EN
  logic [7:0][15:0] pf_q;
  logic             pf_full, rd_pend;

  // Fetch the next word near the end of the current one; a read landing on
  // the final handshake is forwarded straight from din.
  assign pf_rd       = (state == SEND) && (idx >= 3'd6) && !pf_full && !rd_pend && !empty;
  assign refill      = pf_full || rd_pend;
  assign refill_word = pf_full ? pf_q : din;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pf_q    <= '0;
      pf_full <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= pf_rd;
      if (state == SEND && last && pf_full)
        pf_full <= 1'b0;
      else if (state == SEND && rd_pend && !last) begin
        pf_q    <= din;
        pf_full <= 1'b1;
      end
    end
  end
`else
  assign pf_rd       = 1'b0;
  assign refill      = 1'b0;
  assign refill_word = din;
`endif

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        rd_en = !empty && RST;
        if (!empty) state_nxt = WAIT;
      end
      WAIT: state_nxt = SEND;
      SEND: begin
        rd_en = pf_rd;
        // A read issued on the final handshake behaves like the IDLE read.
        if (last) state_nxt = refill ? SEND : (pf_rd ? WAIT : IDLE);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      word_q   <= '0;
      idx      <= '0;
      pair_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT) begin
        word_q <= din;
        idx    <= '0;
      end else if (hs) begin
        idx <= idx + 3'd1;
        if (last && refill) word_q <= refill_word;
      end
      if (hs) pair_cnt <= pair_cnt + 1'b1;
    end
  end

  assign out_ad1 = out_valid ? word_q[idx][7:0]  : 8'h00;
  assign out_ad2 = out_valid ? word_q[idx][15:8] : 8'h00;
  assign sof     = out_valid && (pair_cnt == '0);
  assign eof     = out_valid && (pair_cnt == CNT_W'(FRAME_LEN - 1));

endmodule

// File: tb/tb_comm_unpack.sv
// Bench for comm_unpack: FIFO model plus a pair-stream reference computed from word/pair arithmetic.
module tb_comm_unpack;
  localparam int FL = 64;
`ifdef COMM_UNPACK_PREFETCH_EN
  localparam int WGAP = 1;
`else
  localparam int WGAP = 3;
`endif
  localparam logic [127:0] CONST_W = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;

  logic         CLK = 1'b0, RST = 1'b0;
  logic         rd_en, empty, out_valid, sof, eof;
  logic         out_ready = 1'b0;
  logic [127:0] din = '0;
  logic [7:0]   out_ad1, out_ad2;

  always #5 CLK = ~CLK;

  comm_unpack #(.FRAME_LEN(FL), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .rd_en(rd_en), .din(din), .empty(empty),
    .out_ad1(out_ad1), .out_ad2(out_ad2), .out_valid(out_valid),
    .out_ready(out_ready), .sof(sof), .eof(eof)
  );

  logic [127:0] mem [0:63];
  int rd_ptr = 0, avail = 0;

  // Standard (non-FWFT) FIFO: data appears the cycle after the read strobe.
  assign empty = (rd_ptr >= avail);
  always @(posedge CLK) if (rd_en && !empty) begin
    din    <= mem[rd_ptr];
    rd_ptr <= rd_ptr + 1;
  end

  int total = 0, bad = 0, cyc = 0, p = 0, base = 0, t0 = 0, pb = 0;
  int mode = 0, stall_pair = -1, stall_left = 0, stall_seen = 0, sof_n = 0, eof_n = 0;
  int hs_at [0:511];
  bit hs_sof [0:511];
  bit stalling = 0, pv_hold = 0;
  logic [17:0] pv_out = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [127:0] w;
    int k;
    if (pv_hold) check("hold", {13'd0, out_valid, out_ad1, out_ad2, sof, eof}, {13'd0, 1'b1, pv_out});
    if (out_valid) begin
      w = mem[base + p / 8];
      k = p % 8;
      check("pair", {14'd0, out_ad1, out_ad2, sof, eof},
            {14'd0, w[16*k +: 8], w[16*k+8 +: 8], (p % FL) == 0, (p % FL) == FL - 1});
    end else
      check("idle_out", {14'd0, out_ad1, out_ad2, sof, eof}, 0);
    check("rd_on_empty", {31'd0, rd_en & empty}, 0);
    if (stalling) begin
      check("bp_rd", {31'd0, rd_en}, 0);
      check("bp_ad", {16'd0, out_ad1, out_ad2}, 32'h0607);
      stall_seen++;
    end
    if (out_valid && out_ready) begin
      hs_at[p]  = cyc;
      hs_sof[p] = sof;
      if (sof) sof_n++;
      if (eof) eof_n++;
      p++;
    end
    pv_hold = out_valid && !out_ready;
    pv_out  = {out_ad1, out_ad2, sof, eof};
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
    stalling = 0;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default:
        if (out_valid && p == stall_pair && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          stalling = 1;
        end else out_ready = 1'b1;
    endcase
    #1 sample();
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && p < target; i++) step();
    check(tag, p, target);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    base = rd_ptr;
    p = 0;
    pv_hold = 0;
    #1;
    check("rst_out", {27'd0, rd_en, out_valid, sof, eof, 1'b0}, 0);
    check("rst_ad", {16'd0, out_ad1, out_ad2}, 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic release_rst();
    @(negedge CLK);
    RST = 1'b1;
    cyc++;
    t0 = cyc;
    #1;
    check("rel_rd", {31'd0, rd_en}, {31'd0, !empty});
    sample();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[0] = CONST_W;
    mem[2] = CONST_W;
    avail = 2;
    do_reset();
    release_rst();
    check("rel_rd1", {31'd0, rd_en}, 1);

    // unpack order and word-to-word spacing
    mode = 0;
    run_until(16, 60, "unpack_cnt");
    check("first_lat", hs_at[0] - t0, 2);
    check("first_pair", {hs_sof[0], 31'd0}, {1'b1, 31'd0});
    check("in_word_span", hs_at[7] - hs_at[0], 7);
    check("word_gap", hs_at[8] - hs_at[7], WGAP);

    // FIFO empty: block parks with no reads
    repeat (6) begin
      step();
      check("empty_idle", {30'd0, rd_en, out_valid}, 0);
    end
    avail = 3;
    #1 check("resume_rd", {31'd0, rd_en}, 1);

    // backpressure on pair 3 of a known word
    mode = 2; stall_pair = 19; stall_left = 5; stall_seen = 0;
    run_until(24, 60, "bp_cnt");
    check("bp_stalls", stall_seen, 5);

    // framing over 16 words with random ready
    do_reset();
    avail = 19;
    mode = 1; sof_n = 0; eof_n = 0;
    release_rst();
    run_until(128, 2000, "frame_cnt");
    check("sof_count", sof_n, 2);
    check("eof_count", eof_n, 2);

    // 32-pair burst: prefetch gives back-to-back pairs across words
    mode = 0;
    avail = 23;
    pb = p;
    run_until(pb + 32, 200, "burst_cnt");
    check("burst_span", hs_at[pb + 31] - hs_at[pb], 31 + 3 * (WGAP - 1));

    // reset mid-word: partial word dropped, next word starts a fresh frame
    avail = 25;
    run_until(pb + 35, 100, "mid_cnt");
    do_reset();
    release_rst();
    run_until(1, 20, "post_rst_first");
    check("post_rst_sof", {31'd0, hs_sof[0]}, 1);
    run_until(8, 40, "post_rst_word");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
